// File: rtl/seq_chunk_adder.sv
// Multi-cycle adder/subtractor: WIDTH-bit operands summed CHUNK bits per cycle, carry kept in a register.
// Latency: N = WIDTH/CHUNK cycles from the accepting edge to done; one operation every N+1 cycles.
// Backpressure: start is only sampled while idle; requests made while busy are dropped, never queued.
module seq_chunk_adder #(
    parameter int WIDTH = 64,
    parameter int CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] S,
    output logic             Cout,
    output logic             overflow
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic             carry_reg;
    logic [KW-1:0]    k;
    logic             a_msb;
    logic             b_msb;
    logic [CHUNK:0]   csum;
    logic             accept;
    logic             last;

    // Operands shift right each cycle so the active chunk always sits in the low bits;
    // finished chunks enter the accumulator from the top.
    always_comb begin
        csum    = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]} + {{CHUNK{1'b0}}, carry_reg};
        acc_nxt = (acc >> CHUNK) | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (k == K_LAST) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy   = (state == RUN);
        accept = (state == IDLE) && start;
        last   = (state == RUN) && (k == K_LAST);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            acc       <= '0;
            carry_reg <= 1'b0;
            k         <= '0;
            a_msb     <= 1'b0;
            b_msb     <= 1'b0;
            done      <= 1'b0;
            S         <= '0;
            Cout      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                a_reg     <= A;
                b_reg     <= sub ? ~B : B;
                carry_reg <= Cin ^ sub;
                k         <= '0;
                acc       <= '0;
                a_msb     <= A[WIDTH-1];
                b_msb     <= sub ? ~B[WIDTH-1] : B[WIDTH-1];
            end else if (busy) begin
                a_reg     <= a_reg >> CHUNK;
                b_reg     <= b_reg >> CHUNK;
                carry_reg <= csum[CHUNK];
                acc       <= acc_nxt;
                if (last) begin
                    k        <= '0;
                    S        <= acc_nxt;
                    Cout     <= csum[CHUNK];
                    overflow <= (a_msb == b_msb) && (acc_nxt[WIDTH-1] != a_msb);
                    done     <= 1'b1;
                end else begin
                    k <= k + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/seq_chunk_adder.md
Name: seq_chunk_adder

Overview:
- Parametrised multi-cycle adder/subtractor. Adds two WIDTH-bit operands CHUNK bits per clock, rippling carry between chunks through a register.
- Successor to the fixed 64-bit combinational ripple adder. Adds a start/done handshake, a subtract mode and a signed-overflow flag.
- Trades latency for a short critical path. Used where a full-width combinational carry chain misses timing.

Parameters:
- WIDTH, 64, operand/result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 16, bits processed per cycle; 1 <= CHUNK <= WIDTH. N = WIDTH/CHUNK cycles per operation.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = A+B+Cin, 1 = A-B (A + ~B + (Cin^1)).
- A  input  WIDTH  operand A, latched on accepted start.
- B  input  WIDTH  operand B, latched on accepted start.
- Cin  input  1  carry-in, latched on accepted start.
- busy  output  1  high while operation in progress.
- done  output  1  one-cycle pulse: result valid.
- S  output  WIDTH  result, registered.
- Cout  output  1  final carry out (subtract: 1 = no borrow).
- overflow  output  1  two's-complement signed overflow of the full-width result.

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE; busy=0, done=0, S=0, Cout=0, overflow=0.
  - Internal operand, accumulator, carry and chunk-index registers cleared.
  - Reset overrides start and any in-flight operation; partial results are discarded and not reported.
- States: IDLE, RUN.
- IDLE:
  - If start=1 at edge E0: latch A, Beff = sub ? ~B : B, cin_eff = Cin ^ sub; chunk index k=0; state->RUN; busy=1 after E0.
  - If start=0, remain in IDLE.
- RUN, at edge Ej (j = 1..N):
  - Compute {c, sum} = A[k*CHUNK +: CHUNK] + Beff[k*CHUNK +: CHUNK] + carry_reg.
  - carry_reg = cin_eff for k=0. Write sum into the accumulator slice k; carry_reg <= c; k <= k+1.
- Completion at edge EN:
  - S <= full accumulator including the last slice; Cout <= carry out of chunk N-1.
  - overflow <= (A[W-1] == Beff[W-1]) && (S[W-1] != A[W-1]).
  - done=1, busy=0, state->IDLE.
- done deasserts at edge EN+1 unless a new operation completes there, which is impossible for N>=1.
- Latency: done high during the cycle after edge EN, i.e. N cycles after the accepting edge.
- Throughput: one operation per N+1 cycles. A start held high through completion is accepted at EN+1.
- Outputs S/Cout/overflow change only at completion edges or reset. They hold their last result through subsequent IDLE and RUN periods.
- start while busy=1 is ignored; no queueing, no error flag. A/B/Cin/sub changes during RUN have no effect.
- Wrap-around: the sum is modulo 2^WIDTH; the carry beyond the MSB appears only on Cout.
- Chunk index: ceil(log2(N)) bits, minimum 1. Returns to 0 on completion.
- N=1 (CHUNK=WIDTH): single RUN cycle; done at E1.

Test Plan (WIDTH=64, CHUNK=16 unless stated):
- Reset:
  - Hold rst=1 for 2 cycles with start=1 -> busy=0, done=0, S=0, Cout=0, overflow=0.
  - Release rst, start=0 -> remains idle, no done.
- Cross-chunk carry:
  - A=0xFFFF_FFFF_FFFF_FFFF, B=0x1, Cin=0, sub=0, start at E0 -> busy high E0..E4.
  - done pulses for exactly one cycle after E4; S=0, Cout=1, overflow=0.
- Subtract:
  - A=5, B=7, sub=1 -> S=0xFFFF_FFFF_FFFF_FFFE, Cout=0, overflow=0.
  - A=7, B=5, sub=1 -> S=2, Cout=1.
- Signed overflow:
  - A=0x7FFF_FFFF_FFFF_FFFF, B=1, sub=0 -> S=0x8000_0000_0000_0000, overflow=1, Cout=0.
  - A=0x8000_0000_0000_0000, B=1, sub=1 -> S=0x7FFF_FFFF_FFFF_FFFF, overflow=1.
- Busy and mid-operation reset:
  - Pulse start with a new A at E2 during an operation -> ignored; the first result is unaffected and only one done occurs.
  - Assert rst at E2 of a new operation -> busy=0 next cycle, no done, S retains 0.
- Parameter variant:
  - Set CHUNK=64 (N=1) and apply the carry vectors from the cross-chunk carry test -> done one cycle after the accepting edge with identical results.
  - Set CHUNK=1 -> done 64 cycles after the accepting edge.
  - Compare all results against a behavioural A+B+Cin reference model.
